// File: rtl/loadable_weight_comp_cell.sv
`default_nettype none
// ============================================================================
// Module  : loadable_weight_comp_cell
// Brief   : Weight-stationary multiply-accumulate cell with a loadable weight
//           memory, chunked dot-product accumulation, value pass-through and a
//           daisy-chained result bus with a single-entry pending slot.
// Revision: 1.0 - initial release
// ============================================================================
module loadable_weight_comp_cell #(
  parameter int DATA_WIDTH    = 32,
  parameter int WEIGHT_WIDTH  = 8,
  parameter int WEIGHT_AMOUNT = 16,
  parameter int INPUT_AMOUNT  = 4,
  parameter bit SIGNED        = 1'b0,
  parameter bit RELU          = 1'b0
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  weight_load_enable,
  input  logic [$clog2(WEIGHT_AMOUNT)-1:0]      weight_load_addr,
  input  logic [WEIGHT_WIDTH-1:0]               weight_load_data,
  input  logic [DATA_WIDTH-1:0]                 input_index,
  input  logic [INPUT_AMOUNT*DATA_WIDTH-1:0]    input_value,
  input  logic                                  input_enable,
  input  logic [DATA_WIDTH:0]                   input_result,
  output logic [DATA_WIDTH-1:0]                 output_index,
  output logic [INPUT_AMOUNT*DATA_WIDTH-1:0]    output_value,
  output logic                                  output_enable,
  output logic [DATA_WIDTH:0]                   output_result,
  output logic                                  error_flag
);

  localparam int ADDR_WIDTH = $clog2(WEIGHT_AMOUNT);

  // Index of the chunk that completes a dot product, and the chunk stride.
  localparam logic [DATA_WIDTH-1:0] LAST_INDEX = DATA_WIDTH'(WEIGHT_AMOUNT - INPUT_AMOUNT);
  localparam logic [DATA_WIDTH-1:0] CHUNK_SIZE = DATA_WIDTH'(INPUT_AMOUNT);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [WEIGHT_WIDTH-1:0]            weight_q [WEIGHT_AMOUNT];
  logic [WEIGHT_WIDTH-1:0]            weight_d [WEIGHT_AMOUNT];
  logic [DATA_WIDTH-1:0]              acc_q, acc_d;
  logic                               pend_valid_q, pend_valid_d;
  logic [DATA_WIDTH-1:0]              pend_data_q, pend_data_d;
  logic                               error_q, error_d;
  logic [DATA_WIDTH-1:0]              output_index_q, output_index_d;
  logic [INPUT_AMOUNT*DATA_WIDTH-1:0] output_value_q, output_value_d;
  logic                               output_enable_q, output_enable_d;
  logic [DATA_WIDTH:0]                output_result_q, output_result_d;

  // --------------------------------------------------------------------------
  // Chunk classification
  // --------------------------------------------------------------------------
  logic w_aligned;
  logic w_in_range;
  logic w_legal;
  logic w_illegal;
  logic w_final;

  assign w_aligned  = (input_index % CHUNK_SIZE) == '0;
  assign w_in_range = input_index <= LAST_INDEX;
  assign w_legal    = input_enable & w_aligned & w_in_range;
  assign w_illegal  = input_enable & ~(w_aligned & w_in_range);
  assign w_final    = w_legal & (input_index == LAST_INDEX);

  // --------------------------------------------------------------------------
  // Per-lane products. Weights are widened to the data width first so that the
  // truncated product is correct for both signed and unsigned operation; the
  // low DATA_WIDTH bits of a product do not depend on operand signedness once
  // both operands have been extended to that width.
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] w_prod [INPUT_AMOUNT];

  for (genvar gi = 0; gi < INPUT_AMOUNT; gi++) begin : g_lane
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [WEIGHT_WIDTH-1:0] w_weight;
    logic [DATA_WIDTH-1:0]   w_weight_ext;

    // Only meaningful for legal chunks, which never run past the memory end.
    assign w_addr   = input_index[ADDR_WIDTH-1:0] + ADDR_WIDTH'(gi);
    assign w_weight = weight_q[w_addr];

    if (SIGNED) begin : g_sext
      assign w_weight_ext = DATA_WIDTH'($signed(w_weight));
    end else begin : g_zext
      assign w_weight_ext = DATA_WIDTH'(w_weight);
    end

    assign w_prod[gi] = input_value[DATA_WIDTH*gi +: DATA_WIDTH] * w_weight_ext;
  end

  // --------------------------------------------------------------------------
  // Chunk sum and the value a final chunk would publish
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] w_sum;
  logic [DATA_WIDTH-1:0] w_result;

  // Accumulate all lanes on top of the running sum (index 0 restarts it).
  always_comb begin
    w_sum = (input_index == '0) ? '0 : acc_q;
    for (int i = 0; i < INPUT_AMOUNT; i++) begin
      w_sum = w_sum + w_prod[i];
    end
  end

  // Negative final sums are clamped only when both ReLU and signed mode are on.
  assign w_result = (RELU && SIGNED && w_sum[DATA_WIDTH-1]) ? '0 : w_sum;

  // --------------------------------------------------------------------------
  // Next-state: weight writes, accumulator, pass-through, result arbitration
  // --------------------------------------------------------------------------
  always_comb begin
    weight_d        = weight_q;
    acc_d           = acc_q;
    pend_valid_d    = pend_valid_q;
    pend_data_d     = pend_data_q;
    error_d         = error_q;
    output_index_d  = '0;
    output_value_d  = '0;
    output_enable_d = 1'b0;
    output_result_d = '0;

    // The chunk above already read weight_q, so a same-cycle write is unseen.
    if (weight_load_enable) begin
      weight_d[weight_load_addr] = weight_load_data;
    end

    // Pass-through is independent of chunk legality.
    if (input_enable) begin
      output_index_d  = input_index;
      output_value_d  = input_value;
      output_enable_d = 1'b1;
    end

    if (w_illegal) begin
      error_d = 1'b1;
    end

    if (w_legal) begin
      acc_d = w_final ? '0 : w_sum;
    end

    // Upstream results have priority, then the pending slot, then a fresh
    // result. A fresh result that cannot go out now is parked in the slot;
    // if the slot is already occupied and stays occupied, it is lost.
    if (input_result[DATA_WIDTH]) begin
      output_result_d = input_result;
      if (w_final) begin
        if (pend_valid_q) begin
          error_d = 1'b1;
        end else begin
          pend_valid_d = 1'b1;
          pend_data_d  = w_result;
        end
      end
    end else if (pend_valid_q) begin
      output_result_d = {1'b1, pend_data_q};
      pend_valid_d    = w_final;
      if (w_final) begin
        pend_data_d = w_result;
      end
    end else if (w_final) begin
      output_result_d = {1'b1, w_result};
    end
  end

  // Register all state; reset clears everything including the weight memory.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      weight_q        <= '{default: '0};
      acc_q           <= '0;
      pend_valid_q    <= 1'b0;
      pend_data_q     <= '0;
      error_q         <= 1'b0;
      output_index_q  <= '0;
      output_value_q  <= '0;
      output_enable_q <= 1'b0;
      output_result_q <= '0;
    end else begin
      weight_q        <= weight_d;
      acc_q           <= acc_d;
      pend_valid_q    <= pend_valid_d;
      pend_data_q     <= pend_data_d;
      error_q         <= error_d;
      output_index_q  <= output_index_d;
      output_value_q  <= output_value_d;
      output_enable_q <= output_enable_d;
      output_result_q <= output_result_d;
    end
  end

  assign output_index  = output_index_q;
  assign output_value  = output_value_q;
  assign output_enable = output_enable_q;
  assign output_result = output_result_q;
  assign error_flag    = error_q;

endmodule
`default_nettype wire

// File: tb/tb_loadable_weight_comp_cell.sv
`default_nettype none
// ============================================================================
// Module  : tb_loadable_weight_comp_cell
// Brief   : Directed bench for loadable_weight_comp_cell. Three instances
//           (unsigned, signed, signed+ReLU) share one stimulus stream and are
//           checked every cycle against an arithmetic reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_loadable_weight_comp_cell;

  localparam int DW = 16;
  localparam int WA = 8;
  localparam int IA = 4;
  localparam int NK = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wle;
  logic [2:0]       wla;
  logic [7:0]       wld;
  logic [DW-1:0]    idx;
  logic [IA*DW-1:0] val;
  logic             en;
  logic [DW:0]      in_res;

  logic [NK-1:0][DW-1:0]    o_idx;
  logic [NK-1:0][IA*DW-1:0] o_val;
  logic [NK-1:0]            o_en;
  logic [NK-1:0][DW:0]      o_res;
  logic [NK-1:0]            o_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Instance 0: unsigned; 1: signed; 2: signed with ReLU.
  for (genvar k = 0; k < NK; k++) begin : g_dut
    loadable_weight_comp_cell #(
      .DATA_WIDTH   (DW),
      .WEIGHT_WIDTH (8),
      .WEIGHT_AMOUNT(WA),
      .INPUT_AMOUNT (IA),
      .SIGNED       (k > 0),
      .RELU         (k == 2)
    ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .weight_load_enable(wle),
      .weight_load_addr  (wla),
      .weight_load_data  (wld),
      .input_index       (idx),
      .input_value       (val),
      .input_enable      (en),
      .input_result      (in_res),
      .output_index      (o_idx[k]),
      .output_value      (o_val[k]),
      .output_enable     (o_en[k]),
      .output_result     (o_res[k]),
      .error_flag        (o_err[k])
    );
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  logic [7:0]    m_w   [WA];
  logic [DW-1:0] m_acc [NK];
  logic          m_pv  [NK];
  logic [DW-1:0] m_pd  [NK];
  logic          m_err [NK];
  logic [DW:0]   m_res [NK];
  logic [DW-1:0]    m_idx;
  logic [IA*DW-1:0] m_val;
  logic             m_en;

  function automatic longint ext16(input logic [15:0] v, input bit sg);
    if (sg) return longint'($signed(v));
    return longint'({48'd0, v});
  endfunction

  function automatic longint ext8(input logic [7:0] v, input bit sg);
    if (sg) return longint'($signed(v));
    return longint'({56'd0, v});
  endfunction

  task automatic model_cycle();
    longint        s;
    logic [DW-1:0] sum;
    logic [DW-1:0] res;
    bit            legal, fin, sg, rl, emitted_new;
    for (int k = 0; k < NK; k++) begin
      sg = (k > 0);
      rl = (k == 2);
      legal = en && (int'(idx) % IA == 0) && (int'(idx) <= WA - IA);
      if (en && !legal) m_err[k] = 1'b1;
      fin = 1'b0;
      res = '0;
      if (legal) begin
        s = (idx == 0) ? 64'sd0 : longint'({48'd0, m_acc[k]});
        for (int i = 0; i < IA; i++)
          s = s + ext16(val[DW*i +: DW], sg) * ext8(m_w[int'(idx) + i], sg);
        sum = DW'(s);
        if (int'(idx) == WA - IA) begin
          fin = 1'b1;
          res = (rl && $signed(sum) < 0) ? '0 : sum;
          m_acc[k] = '0;
        end else begin
          m_acc[k] = sum;
        end
      end
      // Choose what goes out this cycle, then park an unsent fresh result.
      emitted_new = 1'b0;
      if (in_res[DW]) begin
        m_res[k] = in_res;
      end else if (m_pv[k]) begin
        m_res[k] = {1'b1, m_pd[k]};
        m_pv[k]  = 1'b0;
      end else if (fin) begin
        m_res[k] = {1'b1, res};
        emitted_new = 1'b1;
      end else begin
        m_res[k] = '0;
      end
      if (fin && !emitted_new) begin
        if (m_pv[k]) m_err[k] = 1'b1;
        else begin
          m_pv[k] = 1'b1;
          m_pd[k] = res;
        end
      end
    end
    m_idx = en ? idx : '0;
    m_val = en ? val : '0;
    m_en  = en;
    if (wle) m_w[wla] = wld;
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int a = 0; a < WA; a++) m_w[a] = '0;
      for (int k = 0; k < NK; k++) begin
        m_acc[k] = '0; m_pv[k] = 1'b0; m_pd[k] = '0; m_err[k] = 1'b0; m_res[k] = '0;
      end
      m_idx = '0; m_val = '0; m_en = 1'b0;
    end else begin
      model_cycle();
    end
  end

  // Compare every instance against the model on each falling edge.
  always @(negedge clk) begin
    for (int k = 0; k < NK; k++) begin
      check($sformatf("cyc_result[%0d]", k), 64'(o_res[k]), 64'(m_res[k]));
      check($sformatf("cyc_error[%0d]", k),  64'(o_err[k]), 64'(m_err[k]));
      check($sformatf("cyc_index[%0d]", k),  64'(o_idx[k]), 64'(m_idx));
      check($sformatf("cyc_value[%0d]", k),  o_val[k],      m_val);
      check($sformatf("cyc_enable[%0d]", k), 64'(o_en[k]),  64'(m_en));
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chunk(input logic [DW-1:0] i, input logic [DW-1:0] v, input logic [DW:0] r);
    idx = i; val = {IA{v}}; en = 1'b1; in_res = r;
    tick();
    idx = '0; val = '0; en = 1'b0; in_res = '0;
  endtask

  task automatic load(input int a, input logic [7:0] d);
    wle = 1'b1; wla = 3'(a); wld = d;
    tick();
    wle = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; wle = 1'b0; wla = '0; wld = '0;
    idx = '0; val = '0; en = 1'b0; in_res = '0;
    tick(); tick();
    check("reset_result", 64'(o_res[0]), 64'h0);
    check("reset_error",  64'(o_err[0]), 64'h0);
    check("reset_enable", 64'(o_en[0]),  64'h0);
    rst_n = 1'b1;

    for (int a = 0; a < WA; a++) load(a, 8'(a + 1));

    // Basic two-chunk dot product: 10 + 26.
    chunk(16'd0, 16'd1, '0);
    check("chunk0_enable", 64'(o_en[0]), 64'h1);
    chunk(16'd4, 16'd1, '0);
    check("basic_result", 64'(o_res[0]), 64'h10024);
    check("chunk1_index", 64'(o_idx[0]), 64'h4);
    tick();
    check("basic_idle", 64'(o_res[0]), 64'h0);

    // Upstream result wins; our result follows from the slot.
    chunk(16'd0, 16'd1, '0);
    chunk(16'd4, 16'd1, 17'h100AA);
    check("fwd_upstream", 64'(o_res[0]), 64'h100AA);
    tick();
    check("fwd_pending", 64'(o_res[0]), 64'h10024);
    tick();
    check("fwd_idle", 64'(o_res[0]), 64'h0);

    // Restarting at index 0 discards the earlier partial sum.
    chunk(16'd0, 16'd5, '0);
    chunk(16'd0, 16'd1, '0);
    chunk(16'd4, 16'd1, '0);
    check("restart_result", 64'(o_res[0]), 64'h10024);

    // A load in the same cycle as a chunk is not seen by that chunk.
    chunk(16'd0, 16'd1, '0);
    wle = 1'b1; wla = 3'd4; wld = 8'd100;
    chunk(16'd4, 16'd1, '0);
    wle = 1'b0;
    check("load_same_cycle", 64'(o_res[0]), 64'h10024);
    chunk(16'd0, 16'd1, '0);
    chunk(16'd4, 16'd1, '0);
    check("load_next_cycle", 64'(o_res[0]), 64'h10083);
    load(4, 8'd5);

    // Slot emitted while a new final result forms: the new one refills it.
    chunk(16'd0, 16'd1, '0);
    chunk(16'd4, 16'd1, 17'h100AA);
    check("refill_up1", 64'(o_res[0]), 64'h100AA);
    chunk(16'd0, 16'd1, 17'h100BB);
    check("refill_up2", 64'(o_res[0]), 64'h100BB);
    chunk(16'd4, 16'd2, '0);
    check("refill_old", 64'(o_res[0]), 64'h10024);
    tick();
    check("refill_new", 64'(o_res[0]), 64'h1003E);
    tick();
    check("refill_idle", 64'(o_res[0]), 64'h0);

    // Misaligned index: error, pass-through, no result; later sums unaffected.
    chunk(16'd2, 16'd1, '0);
    check("illegal_error", 64'(o_err[0]), 64'h1);
    check("illegal_index", 64'(o_idx[0]), 64'h2);
    check("illegal_result", 64'(o_res[0]), 64'h0);
    chunk(16'd0, 16'd1, '0);
    chunk(16'd4, 16'd1, '0);
    check("after_illegal", 64'(o_res[0]), 64'h10024);
    check("error_sticky", 64'(o_err[0]), 64'h1);

    // Reset mid-sequence clears weights, accumulator and error.
    chunk(16'd0, 16'd1, '0);
    rst_n = 1'b0;
    tick();
    check("midrst_result", 64'(o_res[0]), 64'h0);
    check("midrst_index",  64'(o_idx[0]), 64'h0);
    check("midrst_enable", 64'(o_en[0]),  64'h0);
    check("midrst_error",  64'(o_err[0]), 64'h0);
    rst_n = 1'b1;
    chunk(16'd4, 16'd1, '0);
    check("zero_weights", 64'(o_res[0]), 64'h10000);

    // Slot overflow: second result dropped, first one kept.
    for (int a = 0; a < WA; a++) load(a, 8'(a + 1));
    chunk(16'd0, 16'd1, '0);
    chunk(16'd4, 16'd1, 17'h100AA);
    check("ovf_no_error_yet", 64'(o_err[0]), 64'h0);
    chunk(16'd0, 16'd1, 17'h100BB);
    chunk(16'd4, 16'd2, 17'h100CC);
    check("ovf_upstream", 64'(o_res[0]), 64'h100CC);
    check("ovf_error", 64'(o_err[0]), 64'h1);
    tick();
    check("ovf_kept", 64'(o_res[0]), 64'h10024);
    tick();
    check("ovf_idle", 64'(o_res[0]), 64'h0);

    // All weights 0xFF, all values 2: unsigned / signed / signed+ReLU.
    for (int a = 0; a < WA; a++) load(a, 8'hFF);
    chunk(16'd0, 16'd2, '0);
    chunk(16'd4, 16'd2, '0);
    check("ff_unsigned", 64'(o_res[0]), 64'h10FF0);
    check("ff_signed",   64'(o_res[1]), 64'h1FFF0);
    check("ff_relu",     64'(o_res[2]), 64'h10000);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
